des_expand_xor: RTL and testbench
=================================

DES_EXPAND_XOR -- requirements
Module: des_expand_xor

Interface
REQ-001 Parameter TAG_W, default 4, width of the sideband tag (round index) carried alongside each datum.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream asserts when in_r/in_k/in_tag hold a datum.
REQ-005 in_ready  output  1  block can accept a datum this cycle.
REQ-006 in_r  input  32  right half R, DES bit 1 = in_r[31], bit 32 = in_r[0].
REQ-007 in_k  input  48  round subkey, DES bit 1 = in_k[47].
REQ-008 in_tag  input  TAG_W  sideband, passed through unchanged.
REQ-009 out_valid  output  1  out_sin/out_tag hold a datum.
REQ-010 out_ready  input  1  downstream S-box stage accepts the datum this cycle.
REQ-011 out_sin  output  48  E(R) XOR K; [47:42] feeds S1, [41:36] feeds S2 (6-bit sbox input), ... [5:0] feeds S8.
REQ-012 out_tag  output  TAG_W  tag of the datum on out_sin.

Function
REQ-013 Input transfer occurs on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-014 Expansion group j (j=1..8) SHALL be DES bits 4j-4 .. 4j+1 of R, MSB first, with bit 0 meaning bit 32 and bit 33 meaning bit 1 (standard DES E table).
REQ-015 out_sin SHALL equal E(in_r) XOR in_k of the accepted datum, bit-exact, no arithmetic carry.
REQ-016 Latency SHALL be 1 cycle: a datum accepted in cycle n is presented with out_valid=1 in cycle n+1 at the earliest.
REQ-017 Data SHALL leave in acceptance order; none dropped, duplicated or reordered.
REQ-018 While out_valid=1 and out_ready=0, out_sin and out_tag SHALL hold stable.
REQ-019 out_valid SHALL not deassert without an output transfer.
REQ-020 Simultaneous input and output transfer in one cycle SHALL sustain one datum per cycle throughput.
REQ-021 in_r/in_k/in_tag are don't-care when in_valid=0; no state change results.
REQ-022 Output register and data path SHALL be fully registered (out_sin/out_tag driven from flops).

Reset
REQ-023 rst_n=0 SHALL immediately, without clock, force out_valid=0, out_sin=0, out_tag=0 and clear all buffer occupancy.
REQ-024 Data held at reset assertion SHALL be discarded; in_ready SHALL be 1 after reset deasserts (not during reset).
REQ-025 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro DES_EXPAND_XOR_SKID_EN defined: two-entry skid buffer (main + skid register); in_ready SHALL be a flop output (= skid entry empty), with no combinational path from out_ready; when full, in_ready=0 until an output transfer.
REQ-027 Macro undefined: single output register; in_ready SHALL equal !out_valid || out_ready (combinational); full throughput still holds.
REQ-028 Functional results (REQ-014..REQ-020) SHALL be identical in both builds; only in_ready timing differs.

Verification
REQ-029 in_r=32'h0000_0000, in_k=48'h0 -> out_sin=48'h0000_0000_0000 one cycle later, out_tag=in_tag.
REQ-030 in_r=32'h8000_0001, in_k=0 -> out_sin=48'hC000_0000_0003 (wrap bits at both ends).
REQ-031 in_r=32'hF0AA_F0AA, in_k=48'h1B02_EFFC_7072 -> out_sin=48'h6117_BA86_6527.
REQ-032 Stream of 16 data, tags 0..15, with random out_ready stalls -> all 16 emerge in order, values hold stable while stalled; with SKID_EN, in_ready drops only after two data held, without SKID_EN in_ready tracks out_ready.
REQ-033 out_ready=1, in_valid=1 continuously for 32 cycles -> 32 outputs on consecutive cycles (no bubbles).
REQ-034 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 and out_sin=0 immediately; held datum never emitted; next datum after release emitted correctly.

Source files
------------

// File: rtl/des_expand_xor_if.sv
// Handshake bundle for the DES expansion/key-mix stage.
// slave  : seen by des_expand_xor (accepts R/K/tag, presents E(R)^K)
// master : seen by whatever feeds the stage and drains its output
interface des_expand_xor_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_r;
  logic [47:0]      in_k;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_sin;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_r, in_k, in_tag, out_ready,
    output in_ready, out_valid, out_sin, out_tag
  );

  modport master (
    output in_valid, in_r, in_k, in_tag, out_ready,
    input  in_ready, out_valid, out_sin, out_tag
  );
endinterface

// File: rtl/des_expand_xor.sv
// DES round front end: expands the 32-bit right half R to 48 bits with the
// standard E table and XORs the round subkey, one registered stage.
// out_sin[47:42] feeds S1 ... out_sin[5:0] feeds S8; the tag rides along.
// Build option DES_EXPAND_XOR_SKID_EN: two-entry skid buffer with a
// registered in_ready. Without it a single output register is used and
// in_ready is !out_valid || out_ready.
module des_expand_xor #(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  des_expand_xor_if.slave    bus
);

  // DES E table. DES bit b of R lives at in_r[32-b]; each 6-bit group j
  // takes DES bits 4j-4..4j+1 with bit 0 wrapping to 32 and 33 to 1.
  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27],
            r[28:23],
            r[24:19],
            r[20:15],
            r[16:11],
            r[12:7],
            r[8:3],
            r[4:0], r[31]};
  endfunction

  logic [47:0]      in_sin;
  logic             accept;
  logic             pop;
  logic             ready;
  logic             main_valid;
  logic [47:0]      main_sin;
  logic [TAG_W-1:0] main_tag;

  assign in_sin = expand(bus.in_r) ^ bus.in_k;
  assign pop    = main_valid && bus.out_ready;
  assign accept = bus.in_valid && ready;

`ifdef DES_EXPAND_XOR_SKID_EN
  logic             skid_valid;
  logic [47:0]      skid_sin;
  logic [TAG_W-1:0] skid_tag;
  logic             ready_q;

  assign ready = ready_q;

  // Main register presents data; the skid register catches the one datum
  // that can arrive while main is stalled. ready_q mirrors "skid empty"
  // from a flop so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_sin   <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_sin   <= '0;
      skid_tag   <= '0;
      ready_q    <= 1'b1;
    end else if (pop && skid_valid) begin
      main_sin   <= skid_sin;
      main_tag   <= skid_tag;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (pop) begin
      main_valid <= accept;
      if (accept) begin
        main_sin <= in_sin;
        main_tag <= bus.in_tag;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_sin   <= in_sin;
        main_tag   <= bus.in_tag;
      end else begin
        skid_valid <= 1'b1;
        skid_sin   <= in_sin;
        skid_tag   <= bus.in_tag;
        ready_q    <= 1'b0;
      end
    end
  end
`else
  assign ready = !main_valid || bus.out_ready;

  // Single output register: load on accept, empty when drained with
  // nothing arriving; data bits only move on accept so stalls hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_sin   <= '0;
      main_tag   <= '0;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_sin   <= in_sin;
      main_tag   <= bus.in_tag;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = ready;
  assign bus.out_valid = main_valid;
  assign bus.out_sin   = main_sin;
  assign bus.out_tag   = main_tag;

endmodule

// File: tb/tb_des_expand_xor.sv
// Self-checking bench for des_expand_xor: directed E-table vectors, a
// randomly stalled stream, back-to-back throughput and mid-stream reset,
// all scored against a rule-level reference model and an ordered queue.
module tb_des_expand_xor;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [47:0]      sin;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  item_t expq[$];

  des_expand_xor_if #(.TAG_W(TAG_W)) bus();

  des_expand_xor #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something stalls forever
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: build E(R) straight from the group rule, then mix the key.
  function automatic logic [47:0] ref_sin(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    int b;
    e = '0;
    for (int j = 1; j <= 8; j++) begin
      for (int m = 0; m < 6; m++) begin
        b = 4 * j - 4 + m;
        if (b == 0) b = 32;
        else if (b == 33) b = 1;
        e[47 - 6 * (j - 1) - m] = r[32 - b];
      end
    end
    return e ^ k;
  endfunction

  // Drive one cycle at the falling edge and report what will transfer on
  // the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [47:0] k,
                               input logic [TAG_W-1:0] tag, input logic ordy,
                               output logic acc, output logic pop);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_r      = r;
    bus.in_k      = k;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    acc = bus.in_valid && bus.in_ready;
    pop = bus.out_valid && bus.out_ready;
  endtask

  task automatic test_reset();
    logic acc, pop;
    logic [31:0] r;
    logic [47:0] k;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_k = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sin !== 48'h0) $display("[TB] FAIL reset_out_sin: got %h expected 0", bus.out_sin);
    else n_pass++;
    n_checks++;
    if (bus.out_tag !== '0) $display("[TB] FAIL reset_out_tag: got %h expected 0", bus.out_tag);
    else n_pass++;
    // Offer a datum at release so the first rising edge can take it
    r = $urandom;
    k = {16'($urandom), $urandom};
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_r = r; bus.in_k = k; bus.in_tag = 4'hA; bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.in_ready);
    else n_pass++;
    if (bus.in_valid && bus.in_ready) expq.push_back('{sin: ref_sin(r, k), tag: 4'hA});
    applyStimulus(1'b0, '0, '0, '0, 1'b1, acc, pop);
    n_checks++;
    if (!pop || expq.size() == 0)
      $display("[TB] FAIL first_transfer: got out_valid=%b expected 1", bus.out_valid);
    else if ({bus.out_sin, bus.out_tag} !== {expq[0].sin, expq[0].tag})
      $display("[TB] FAIL first_transfer: got %h/%h expected %h/%h",
               bus.out_sin, bus.out_tag, expq[0].sin, expq[0].tag);
    else n_pass++;
    if (pop && expq.size() != 0) void'(expq.pop_front());
  endtask

  task automatic test_directed();
    logic [31:0] dr[3]   = '{32'h0000_0000, 32'h8000_0001, 32'hF0AA_F0AA};
    logic [47:0] dk[3]   = '{48'h0, 48'h0, 48'h1B02_EFFC_7072};
    logic [47:0] dexp[3] = '{48'h0000_0000_0000, 48'hC000_0000_0003, 48'h6117_BA86_6527};
    logic acc, pop;
    logic [TAG_W-1:0] tag;
    for (int i = 0; i < 3; i++) begin
      tag = TAG_W'($urandom);
      applyStimulus(1'b1, dr[i], dk[i], tag, 1'b1, acc, pop);
      n_checks++;
      if (acc !== 1'b1) $display("[TB] FAIL directed_accept[%0d]: got %b expected 1", i, acc);
      else n_pass++;
      applyStimulus(1'b0, '0, '0, '0, 1'b1, acc, pop);
      n_checks++;
      if (pop !== 1'b1) $display("[TB] FAIL directed_latency[%0d]: got out_valid=%b expected 1", i, bus.out_valid);
      else n_pass++;
      n_checks++;
      if ({bus.out_sin, bus.out_tag} !== {dexp[i], tag})
        $display("[TB] FAIL directed_value[%0d]: got %h/%h expected %h/%h", i, bus.out_sin, bus.out_tag, dexp[i], tag);
      else n_pass++;
    end
  endtask

  task automatic test_stall_stream();
    logic acc, pop, ordy;
    logic [31:0] r;
    logic [47:0] k;
    logic exp_ready;
    int sent = 0, got = 0, cyc = 0;
    while (got < 16 && cyc < 500) begin
      r = $urandom;
      k = {16'($urandom), $urandom};
      ordy = ($urandom_range(0, 2) != 0);
      applyStimulus(sent < 16, r, k, TAG_W'(sent), ordy, acc, pop);
      n_checks++;
      if (bus.out_valid !== (expq.size() != 0))
        $display("[TB] FAIL stream_valid: got %b expected %b", bus.out_valid, expq.size() != 0);
      else n_pass++;
`ifdef DES_EXPAND_XOR_SKID_EN
      exp_ready = (expq.size() < 2);
`else
      exp_ready = (expq.size() == 0) || ordy;
`endif
      n_checks++;
      if (bus.in_ready !== exp_ready)
        $display("[TB] FAIL stream_ready: got %b expected %b", bus.in_ready, exp_ready);
      else n_pass++;
      if (pop) begin
        n_checks++;
        if (expq.size() == 0)
          $display("[TB] FAIL stream_extra: got %h/%h expected none", bus.out_sin, bus.out_tag);
        else if ({bus.out_sin, bus.out_tag} !== {expq[0].sin, expq[0].tag})
          $display("[TB] FAIL stream_value: got %h/%h expected %h/%h",
                   bus.out_sin, bus.out_tag, expq[0].sin, expq[0].tag);
        else n_pass++;
        if (expq.size() != 0) void'(expq.pop_front());
        got++;
      end
      if (acc) begin
        expq.push_back('{sin: ref_sin(r, k), tag: TAG_W'(sent)});
        sent++;
      end
      cyc++;
    end
    n_checks++;
    if (got != 16) $display("[TB] FAIL stream_count: got %0d expected 16", got);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic acc, pop;
    logic [31:0] r;
    logic [47:0] k;
    int pops = 0;
    for (int i = 0; i <= 32; i++) begin
      r = $urandom;
      k = {16'($urandom), $urandom};
      applyStimulus(i < 32, r, k, TAG_W'(i), 1'b1, acc, pop);
      if (i < 32) begin
        n_checks++;
        if (acc !== 1'b1) $display("[TB] FAIL b2b_accept[%0d]: got %b expected 1", i, acc);
        else n_pass++;
      end
      if (i > 0) begin
        n_checks++;
        if (!pop || expq.size() == 0)
          $display("[TB] FAIL b2b_bubble[%0d]: got out_valid=%b expected 1", i, bus.out_valid);
        else if ({bus.out_sin, bus.out_tag} !== {expq[0].sin, expq[0].tag})
          $display("[TB] FAIL b2b_value[%0d]: got %h/%h expected %h/%h",
                   i, bus.out_sin, bus.out_tag, expq[0].sin, expq[0].tag);
        else n_pass++;
      end
      if (pop && expq.size() != 0) begin
        void'(expq.pop_front());
        pops++;
      end
      if (acc) expq.push_back('{sin: ref_sin(r, k), tag: TAG_W'(i)});
    end
    n_checks++;
    if (pops != 32) $display("[TB] FAIL b2b_count: got %0d expected 32", pops);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic acc, pop;
    logic [31:0] r;
    logic [47:0] k;
    applyStimulus(1'b1, $urandom, {16'($urandom), $urandom}, 4'h3, 1'b0, acc, pop);
    applyStimulus(1'b1, $urandom, {16'($urandom), $urandom}, 4'h4, 1'b0, acc, pop);
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("[TB] FAIL midrst_held: got %b expected 1", bus.out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if ({bus.out_sin, bus.out_tag} !== 52'h0)
      $display("[TB] FAIL midrst_data: got %h/%h expected 0/0", bus.out_sin, bus.out_tag);
    else n_pass++;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    r = $urandom;
    k = {16'($urandom), $urandom};
    applyStimulus(1'b1, r, k, 4'h9, 1'b1, acc, pop);
    n_checks++;
    if (acc !== 1'b1) $display("[TB] FAIL midrst_accept: got %b expected 1", acc);
    else n_pass++;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, acc, pop);
    n_checks++;
    if (!pop || {bus.out_sin, bus.out_tag} !== {ref_sin(r, k), 4'h9})
      $display("[TB] FAIL midrst_after: got %b %h/%h expected 1 %h/9",
               bus.out_valid, bus.out_sin, bus.out_tag, ref_sin(r, k));
    else n_pass++;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, acc, pop);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_idle: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] des_expand_xor bench start");
    test_reset();
    test_directed();
    test_stall_stream();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
